rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
Parametrised N-channel arbitrating multiplexer with a registered output slot and valid/ready handshakes on every channel. It selects one requesting source per cycle using one of three modes: round-robin, fixed priority, or forced select. The winning payload is captured into a one-entry output register. It sits between several producers (fetch, load/store, debug) and one shared consumer such as the memory port of the multicycle core.

Parameters:
NUM_CH, 4, number of input channels (>= 2).
DATA_WIDTH, 32, payload width per channel.
SEL_WIDTH, 2, width of select/index fields; must satisfy 2**SEL_WIDTH >= NUM_CH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_CH*DATA_WIDTH  flattened payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  input  NUM_CH  per-channel request
in_ready  output  NUM_CH  per-channel accept (combinational, one-hot or zero)
mode  input  2  00 round-robin, 01 fixed priority (lowest index wins), 10 forced, 11 treated as 01
sel  input  SEL_WIDTH  channel index used in forced mode
out_data  output  DATA_WIDTH  registered payload
out_valid  output  1  registered valid
out_ready  input  1  consumer accept
out_sel  output  SEL_WIDTH  index of the channel that supplied out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready=0 while rst_n=0.
- slot_free = !out_valid || out_ready.
- Grant (combinational, evaluated every cycle):
  - RR mode: first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_CH.
  - Fixed mode: lowest i with in_valid[i].
  - Forced mode: grant sel only if sel < NUM_CH and in_valid[sel]. Otherwise no grant; other channels are never granted.
- in_ready[g]=1 only when grant g exists and slot_free=1. All other bits are 0.
- Transfer: in_valid[g] && in_ready[g]. On that clock edge: out_data <= channel g payload, out_sel <= g, out_valid <= 1.
- If slot_free and no grant: out_valid <= 0 at the edge. out_data and out_sel hold their values.
- If !slot_free: the output register holds all values (stall), and no input is accepted.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 transfer per cycle when out_ready is held high.
- rr_ptr updates only on a transfer in RR mode: rr_ptr <= (g == NUM_CH-1) ? 0 : g+1. It holds in the other modes and across stalls.
- mode and sel changes take effect in the same-cycle grant computation. A held output word is never altered.
- Producers must hold in_valid and data until accepted. The block does not require this for correctness, but uses whatever is present at the accepting edge.
- A reset asserted mid-transfer drops any held word (out_valid=0 immediately) and returns rr_ptr to 0.

Decomposition:
- Shared package cpu_pkg (or the existing one) holds the mode constants: MODE_RR=2'b00, MODE_FIXED=2'b01, MODE_FORCED=2'b10.
- One natural sub-module: rr_grant, a combinational rotate-priority picker. Inputs: req[NUM_CH], start[SEL_WIDTH], rotate_en. Outputs: grant_valid and grant_idx. With rotate_en=0 it behaves as a fixed-priority picker.
- The output register, the pointer update and the forced-mode override remain in rr_arb_mux.

Test Plan:
- Reset: assert rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. Release; first edge with mode=00 accepts ch0.
- RR fairness: NUM_CH=4, all in_valid=1 continuously, out_ready=1, data_i=32'h1000_000i -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles; one in_ready bit high per cycle.
- Fixed priority: mode=01, in_valid=4'b1010 -> ch1 accepted every cycle, ch3 starved. Drop in_valid[1] -> ch3 accepted next cycle.
- Forced select: mode=10, sel=2, in_valid=4'b1011 -> no grant, out_valid falls to 0. Raise in_valid[2] with data 32'hDEAD_BEEF -> out_data=32'hDEAD_BEEF, out_sel=2 one cycle later.
- Backpressure: out_valid=1 holding 32'hA5A5_0001 with out_ready=0 for 3 cycles -> out_data stable, in_ready=0, rr_ptr unchanged. Raise out_ready -> next word accepted in the same cycle and presented one cycle later.
- Async reset mid-stream: pull rst_n low between edges while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge. After release, RR restarts from ch0.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the arbitrating multiplexer.
package rr_arb_mux_pkg;

  localparam logic [1:0] MODE_RR     = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_FORCED = 2'b10;

endpackage : rr_arb_mux_pkg

// File: rtl/rr_arb_mux_grant.sv
// Combinational rotate-priority picker. With rotate_en=0 the search starts
// at index 0, which makes it a plain lowest-index-wins picker.
module rr_grant #(
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] start,
  input  logic                 rotate_en,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  // Walk offsets from farthest to nearest so the closest requester wins.
  always_comb begin
    int base;
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    base        = rotate_en ? int'(start) : 0;
    if (base >= NUM_CH) base = 0;
    idx = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = base + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_WIDTH'(idx);
      end
    end
  end

endmodule : rr_grant

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux: round-robin / fixed / forced grant feeding a
// one-entry registered output slot with valid/ready on both sides.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [1:0]                   mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_sel
);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic                  slot_free;
  logic                  pick_valid;
  logic [SEL_WIDTH-1:0]  pick_idx;
  logic                  forced_hit;
  logic                  grant_valid;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  xfer;

  assign slot_free = !out_valid_q || out_ready;

  rr_grant #(
    .NUM_CH   (NUM_CH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_grant (
    .req        (in_valid),
    .start      (rr_ptr_q),
    .rotate_en  (mode == MODE_RR),
    .grant_valid(pick_valid),
    .grant_idx  (pick_idx)
  );

  // Forced select: out-of-range sel never matches, so it simply grants nobody.
  always_comb begin
    forced_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_WIDTH'(i) && in_valid[i]) forced_hit = 1'b1;
    end
  end

  // Mode override, one-hot ready and winning payload select.
  always_comb begin
    if (mode == MODE_FORCED) begin
      grant_valid = forced_hit;
      grant_idx   = sel;
    end else begin
      grant_valid = pick_valid;
      grant_idx   = pick_idx;
    end
    xfer     = grant_valid && slot_free && rst_n;
    in_ready = '0;
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        in_ready[i] = xfer;
        win_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state of the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = win_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR)
        rr_ptr_d = (grant_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot and pointer registers; reset drops any held word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule : rr_arb_mux

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: vector table, directed corner sequences, then
// randomized traffic checked against a behavioural model.
module tb_rr_arb_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk, rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_ready;
  logic [1:0]      mode;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready;
  logic [SW-1:0]   out_sel;

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.NUM_CH(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [1:0] md;
    logic [1:0] s;
    logic       ordy;
    logic [3:0] erdy;
    logic       eov;
    logic [1:0] esel;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [31:0] val);
    in_data[ch*DW +: DW] = val;
  endtask

  task automatic apply(input logic [3:0] v, input logic [1:0] md,
                       input logic [1:0] s, input logic ordy);
    in_valid  = v;
    mode      = md;
    sel       = s;
    out_ready = ordy;
  endtask

  // Reference model state
  logic        m_ov;
  logic [31:0] m_data;
  int          m_sel, m_ptr;

  // Expected winner from the arbitration rules; -1 when nobody is granted.
  function automatic int model_grant(input logic [3:0] v, input logic [1:0] md,
                                     input logic [1:0] s, input int ptr);
    if (md == 2'b10) return (int'(s) < N && v[s]) ? int'(s) : -1;
    if (md == 2'b00) begin
      for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
    end
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'b1010, 2'b01, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[7]  = '{4'b1010, 2'b01, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[8]  = '{4'b1000, 2'b01, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[9]  = '{4'b1011, 2'b10, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[10] = '{4'b1111, 2'b10, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{4'b1100, 2'b11, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[12] = '{4'b1111, 2'b00, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[13] = '{4'b1111, 2'b00, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[14] = '{4'b1111, 2'b00, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[15] = '{4'b0011, 2'b00, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[16] = '{4'b0000, 2'b00, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[17] = '{4'b0000, 2'b00, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[18] = '{4'b1000, 2'b10, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3};

    for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + 32'(i));
    apply(4'b1111, 2'b00, 2'd0, 1'b1);

    // Reset state with every channel requesting
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: RR rotation, fixed priority, forced, mode 11, stall
    for (int r = 0; r < 19; r++) begin
      apply(tbl[r].v, tbl[r].md, tbl[r].s, tbl[r].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].erdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].eov));
      chk($sformatf("tbl%0d_out_sel", r), 32'(out_sel), 32'(tbl[r].esel));
      if (tbl[r].eov)
        chk($sformatf("tbl%0d_out_data", r), out_data, 32'h1000_0000 + 32'(tbl[r].esel));
    end

    // Forced select waits for its channel, then carries its payload
    set_data(2, 32'hDEAD_BEEF);
    apply(4'b1011, 2'b10, 2'd2, 1'b1);
    #1; chk("forced_nogrant_rdy", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("forced_nogrant_ov", 32'(out_valid), 32'h0);
    apply(4'b1111, 2'b10, 2'd2, 1'b1);
    #1; chk("forced_grant_rdy", 32'(in_ready), 32'h4);
    @(posedge clk); #1;
    chk("forced_ov", 32'(out_valid), 32'h1);
    chk("forced_data", out_data, 32'hDEAD_BEEF);
    chk("forced_sel", 32'(out_sel), 32'h2);

    // Async reset between edges drops the held word immediately
    apply(4'b1111, 2'b00, 2'd0, 1'b0);
    #2; rst_n = 1'b0;
    #1;
    chk("async_ov", 32'(out_valid), 32'h0);
    chk("async_data", out_data, 32'h0);
    chk("async_rdy", 32'(in_ready), 32'h0);
    #1; rst_n = 1'b1;
    out_ready = 1'b1;
    #1; chk("post_rst_rdy", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("post_rst_sel", 32'(out_sel), 32'h0);
    chk("post_rst_ov", 32'(out_valid), 32'h1);

    // Backpressure: held word survives a 3-cycle stall, pointer does not move
    set_data(1, 32'hA5A5_0001);
    apply(4'b0010, 2'b00, 2'd0, 1'b1);
    #1; chk("bp_load_rdy", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    chk("bp_load_data", out_data, 32'hA5A5_0001);
    for (int c = 0; c < 3; c++) begin
      apply(4'b1111, 2'b00, 2'd0, 1'b0);
      #1; chk($sformatf("bp_stall%0d_rdy", c), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("bp_stall%0d_data", c), out_data, 32'hA5A5_0001);
      chk($sformatf("bp_stall%0d_ov", c), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1; chk("bp_release_rdy", 32'(in_ready), 32'h4);
    @(posedge clk); #1;
    chk("bp_release_sel", 32'(out_sel), 32'h2);
    chk("bp_release_data", out_data, 32'hDEAD_BEEF);

    // Randomized traffic against the behavioural model
    do_reset();
    m_ov = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      logic slot;
      logic [3:0] erdy;
      logic [3:0] v;
      logic [1:0] md, s;
      logic ordy;
      v    = 4'($urandom_range(0, 15));
      md   = 2'($urandom_range(0, 3));
      s    = 2'($urandom_range(0, 3));
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      apply(v, md, s, ordy);
      g    = model_grant(v, md, s, m_ptr);
      slot = !m_ov || ordy;
      erdy = (slot && g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      chk($sformatf("rnd%0d_in_ready", cyc), 32'(in_ready), 32'(erdy));
      if (slot && g >= 0) begin
        m_ov   = 1'b1;
        m_data = in_data[g*DW +: DW];
        m_sel  = g;
        if (md == 2'b00) m_ptr = (g + 1) % N;
      end else if (slot) begin
        m_ov = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_out_valid", cyc), 32'(out_valid), 32'(m_ov));
      chk($sformatf("rnd%0d_out_sel", cyc), 32'(out_sel), 32'(m_sel));
      chk($sformatf("rnd%0d_out_data", cyc), out_data, m_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_arb_mux
